regfile_renamed: RTL and testbench

//  Parametrised architectural register file with per-register rename status (busy bit + ROB tag) for the out-of-order core.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_renamed_if.sv | 30 +++
 rtl/regfile_read_port.sv | 56 +++++
 rtl/regfile_renamed.sv | 72 +++++++
 tb/tb_regfile_renamed.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and typedefs for the renamed register file.
// Pure definitions; no latency or flow control involved.
package regfile_pkg;
    localparam int XLEN   = 32;
    localparam int TAG_W  = 4;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   reg_data_t;
    typedef logic [TAG_W-1:0]  rob_tag_t;
endpackage

// File: rtl/regfile_renamed_if.sv
// Dispatch/commit/flush requests and operand read ports of the renamed register file.
// Master is the core (requests and read addresses), slave is the register file.
interface regfile_renamed_if #(
    parameter int NRD = 2
);
    import regfile_pkg::*;

    logic                    iss_en;
    reg_addr_t               iss_rd;
    rob_tag_t                iss_tag;
    logic                    cmt_en;
    reg_addr_t               cmt_rd;
    rob_tag_t                cmt_tag;
    reg_data_t               cmt_data;
    logic                    flush;
    logic [NRD*REG_AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0]     rd_data;
    logic [NRD-1:0]          rd_busy;
    logic [NRD*TAG_W-1:0]    rd_tag;

    modport master (
        output iss_en, iss_rd, iss_tag, cmt_en, cmt_rd, cmt_tag, cmt_data, flush, rd_addr,
        input  rd_data, rd_busy, rd_tag
    );

    modport slave (
        input  iss_en, iss_rd, iss_tag, cmt_en, cmt_rd, cmt_tag, cmt_data, flush, rd_addr,
        output rd_data, rd_busy, rd_tag
    );
endinterface

// File: rtl/regfile_read_port.sv
// One operand read port: x0 and reset masking, combinational (zero latency), no backpressure.
// REGFILE_BYPASS_EN forwards a same-cycle commit (data and post-commit busy) into the port.
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic      rst_n_i,
    input  logic      rdy_i,
    input  reg_addr_t addr_i,
    input  reg_data_t reg_val_i,
    input  logic      reg_busy_i,
    input  rob_tag_t  reg_tag_i,
    input  logic      iss_en_i,
    input  reg_addr_t iss_rd_i,
    input  logic      cmt_en_i,
    input  reg_addr_t cmt_rd_i,
    input  rob_tag_t  cmt_tag_i,
    input  reg_data_t cmt_data_i,
    input  logic      flush_i,
    output reg_data_t data_o,
    output logic      busy_o,
    output rob_tag_t  tag_o
);
    reg_data_t data_raw;
    logic      busy_raw;
    rob_tag_t  tag_raw;

`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = rdy_i && cmt_en_i && (cmt_rd_i == addr_i);

    always_comb begin
        data_raw = hit ? cmt_data_i : reg_val_i;
        busy_raw = reg_busy_i;
        tag_raw  = reg_tag_i;
        // A younger same-cycle rename of this register keeps it pending.
        if (hit && reg_busy_i && (reg_tag_i == cmt_tag_i) && !(iss_en_i && (iss_rd_i == addr_i)))
            busy_raw = 1'b0;
        if (rdy_i && flush_i) begin
            busy_raw = 1'b0;
            tag_raw  = '0;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{rdy_i, iss_en_i, iss_rd_i, cmt_en_i, cmt_rd_i, cmt_tag_i, cmt_data_i, flush_i};
    assign data_raw  = reg_val_i;
    assign busy_raw  = reg_busy_i;
    assign tag_raw   = reg_tag_i;
`endif

    logic pass;
    assign pass   = rst_n_i && (addr_i != '0);
    assign data_o = pass ? data_raw : '0;
    assign busy_o = pass && busy_raw;
    assign tag_o  = pass ? tag_raw : '0;
endmodule

// File: rtl/regfile_renamed.sv
// Architectural register file with busy/ROB-tag rename state; reads zero-latency, updates next edge.
// rdy_in low freezes all state (no backpressure otherwise); REGFILE_BYPASS_EN adds commit-to-read forwarding.
module regfile_renamed
    import regfile_pkg::*;
#(
    parameter int NRD = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    regfile_renamed_if.slave  bus
);
    reg_data_t [NREGS-1:0] regs_q, regs_d;
    logic      [NREGS-1:0] busy_q, busy_d;
    rob_tag_t  [NREGS-1:0] tag_q,  tag_d;

    // Priority for rename state: flush > issue > commit. Data always takes the commit.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (bus.cmt_en && (bus.cmt_rd != '0)) begin
            regs_d[bus.cmt_rd] = bus.cmt_data;
            if (busy_q[bus.cmt_rd] && (tag_q[bus.cmt_rd] == bus.cmt_tag))
                busy_d[bus.cmt_rd] = 1'b0;
        end
        if (bus.iss_en && (bus.iss_rd != '0)) begin
            busy_d[bus.iss_rd] = 1'b1;
            tag_d[bus.iss_rd]  = bus.iss_tag;
        end
        if (bus.flush) begin
            busy_d = '0;
            tag_d  = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            regs_q <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else if (rdy_in) begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        reg_addr_t addr;
        assign addr = bus.rd_addr[p*REG_AW +: REG_AW];

        regfile_read_port u_port (
            .rst_n_i    (rst_n_in),
            .rdy_i      (rdy_in),
            .addr_i     (addr),
            .reg_val_i  (regs_q[addr]),
            .reg_busy_i (busy_q[addr]),
            .reg_tag_i  (tag_q[addr]),
            .iss_en_i   (bus.iss_en),
            .iss_rd_i   (bus.iss_rd),
            .cmt_en_i   (bus.cmt_en),
            .cmt_rd_i   (bus.cmt_rd),
            .cmt_tag_i  (bus.cmt_tag),
            .cmt_data_i (bus.cmt_data),
            .flush_i    (bus.flush),
            .data_o     (bus.rd_data[p*XLEN +: XLEN]),
            .busy_o     (bus.rd_busy[p]),
            .tag_o      (bus.rd_tag[p*TAG_W +: TAG_W])
        );
    end
endmodule

// File: tb/tb_regfile_renamed.sv
// Directed scenarios then randomized traffic against an array-based reference model.
module tb_regfile_renamed;
    import regfile_pkg::*;
    localparam int NRD = 2;

    logic clk_in = 1'b0;
    logic rst_n_in;
    logic rdy_in;
    always #5 clk_in = ~clk_in;

    regfile_renamed_if #(.NRD(NRD)) bus ();
    regfile_renamed #(.NRD(NRD)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .bus      (bus)
    );

    logic [XLEN-1:0]  m_regs [NREGS];
    logic             m_busy [NREGS];
    logic [TAG_W-1:0] m_tag  [NREGS];
    int vectors    = 0;
    int miscompares = 0;

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
    endtask

    task automatic model_update();
        int c, s;
        if (!rdy_in || !rst_n_in) return;
        c = int'(bus.cmt_rd);
        s = int'(bus.iss_rd);
        if (bus.cmt_en && c != 0) begin
            m_regs[c] = bus.cmt_data;
            if (m_busy[c] && m_tag[c] == bus.cmt_tag) m_busy[c] = 1'b0;
        end
        if (bus.iss_en && s != 0) begin
            m_busy[s] = 1'b1; m_tag[s] = bus.iss_tag;
        end
        if (bus.flush)
            for (int i = 0; i < NREGS; i++) begin m_busy[i] = 1'b0; m_tag[i] = '0; end
    endtask

    task automatic exp_read(input int a, output logic [XLEN-1:0] d, output logic b, output logic [TAG_W-1:0] t);
        d = '0; b = 1'b0; t = '0;
        if (!rst_n_in || a == 0) return;
        d = m_regs[a]; b = m_busy[a]; t = m_tag[a];
`ifdef REGFILE_BYPASS_EN
        if (rdy_in) begin
            if (bus.cmt_en && int'(bus.cmt_rd) == a) begin
                d = bus.cmt_data;
                if (b && t == bus.cmt_tag && !(bus.iss_en && int'(bus.iss_rd) == a)) b = 1'b0;
            end
            if (bus.flush) begin b = 1'b0; t = '0; end
        end
`endif
    endtask

    task automatic chk(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic chk_port(input int p, input string name);
        logic [XLEN-1:0] d; logic b; logic [TAG_W-1:0] t;
        exp_read(int'(bus.rd_addr[p*REG_AW +: REG_AW]), d, b, t);
        chk({name, ".data"}, bus.rd_data[p*XLEN +: XLEN], d);
        chk({name, ".busy"}, XLEN'(bus.rd_busy[p]), XLEN'(b));
        chk({name, ".tag"},  XLEN'(bus.rd_tag[p*TAG_W +: TAG_W]), XLEN'(t));
    endtask

    task automatic chk_const(input int p, input string name, input logic [XLEN-1:0] d, input logic b, input logic [TAG_W-1:0] t);
        chk({name, ".cdata"}, bus.rd_data[p*XLEN +: XLEN], d);
        chk({name, ".cbusy"}, XLEN'(bus.rd_busy[p]), XLEN'(b));
        chk({name, ".ctag"},  XLEN'(bus.rd_tag[p*TAG_W +: TAG_W]), XLEN'(t));
    endtask

    task automatic idle();
        bus.iss_en = 1'b0; bus.iss_rd = '0; bus.iss_tag = '0;
        bus.cmt_en = 1'b0; bus.cmt_rd = '0; bus.cmt_tag = '0; bus.cmt_data = '0;
        bus.flush = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        bus.rd_addr = {REG_AW'(a1), REG_AW'(a0)};
    endtask

    task automatic iss(input int r, input int t);
        bus.iss_en = 1'b1; bus.iss_rd = REG_AW'(r); bus.iss_tag = TAG_W'(t);
    endtask

    task automatic cmt(input int r, input int t, input logic [XLEN-1:0] d);
        bus.cmt_en = 1'b1; bus.cmt_rd = REG_AW'(r); bus.cmt_tag = TAG_W'(t); bus.cmt_data = d;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        model_reset();
        rst_n_in = 1'b0;
        rdy_in   = 1'b1;
        idle();
        set_rd(5, 3);
        #2;
        chk_const(0, "reset_p0", '0, 1'b0, '0);
        chk_const(1, "reset_p1", '0, 1'b0, '0);
        @(negedge clk_in) rst_n_in = 1'b1;
        @(posedge clk_in); #1;

        // 1: asynchronous reset in the middle of a cycle
        cmt(5, 0, 32'h1234); tick(); idle();
        set_rd(5, 0); #1;
        chk_const(0, "t1_r5_written", 32'h1234, 1'b0, '0);
        @(negedge clk_in); #2;
        rst_n_in = 1'b0; model_reset(); #1;
        chk_const(0, "t1_async_clear", '0, 1'b0, '0);
        @(negedge clk_in) rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        chk_const(0, "t1_after_release", '0, 1'b0, '0);

        // 2: rename then matching commit
        iss(3, 7); tick(); idle();
        set_rd(3, 0); #1;
        chk_const(0, "t2_renamed", '0, 1'b1, 4'd7);
        cmt(3, 7, 32'hAA); tick(); idle(); #1;
        chk_const(0, "t2_committed", 32'hAA, 1'b0, 4'd7);

        // 3: stale commit keeps the younger rename
        iss(4, 2); tick();
        iss(4, 5); tick(); idle();
        cmt(4, 2, 32'h11); tick(); idle();
        set_rd(4, 0); #1;
        chk_const(0, "t3_stale", 32'h11, 1'b1, 4'd5);

        // 4: same-cycle issue and commit to one register
        iss(6, 3); cmt(6, 1, 32'h55); tick(); idle();
        set_rd(6, 4); #1;
        chk_const(0, "t4_iss_cmt", 32'h55, 1'b1, 4'd3);

        // 5: flush drops rename state and the concurrent issue, keeps commit data
        for (int i = 1; i <= 8; i++) begin iss(i, i); tick(); end
        idle();
        iss(9, 4); cmt(2, 0, 32'h99); bus.flush = 1'b1; tick(); idle();
        set_rd(9, 2); #1;
        chk_const(0, "t5_r9", '0, 1'b0, '0);
        chk(  "t5_r2.data", bus.rd_data[XLEN +: XLEN], 32'h99);
        chk(  "t5_r2.busy", XLEN'(bus.rd_busy[1]), '0);
        for (int i = 1; i <= 8; i++) begin
            set_rd(i, 9 - i); #1;
            chk_port(0, "t5_sweep");
        end

        // 6: frozen state, x0 writes, commit visibility
        iss(6, 9); #1;
        iss(6, 3); tick(); idle();
        set_rd(6, 0); #1;
        chk_const(0, "t6_pre", 32'h55, 1'b1, 4'd3);
        rdy_in = 1'b0;
        iss(6, 9); cmt(6, 3, 32'hDEAD); bus.flush = 1'b1; tick(); idle();
        rdy_in = 1'b1; #1;
        chk_const(0, "t6_frozen", 32'h55, 1'b1, 4'd3);
        iss(0, 5); cmt(0, 5, 32'hFF); tick(); idle();
        set_rd(0, 6); #1;
        chk_const(0, "t6_x0", '0, 1'b0, '0);
        cmt(7, 0, 32'h77); set_rd(7, 7); #1;
`ifdef REGFILE_BYPASS_EN
        chk("t6_bypass", bus.rd_data[XLEN-1:0], 32'h77);
`else
        chk("t6_no_bypass", bus.rd_data[XLEN-1:0], '0);
`endif
        tick(); idle(); #1;
        chk("t6_r7_next", bus.rd_data[XLEN-1:0], 32'h77);

        // Randomized traffic concentrated on a few registers
        for (int n = 0; n < 400; n++) begin
            int r;
            idle();
            rdy_in = ($urandom % 8) != 0;
            if ($urandom % 2) iss($urandom_range(0, 7), $urandom_range(0, 15));
            if ($urandom % 2) begin
                r = $urandom_range(0, 7);
                cmt(r, ($urandom % 2) ? int'(m_tag[r]) : $urandom_range(0, 15), $urandom);
            end
            bus.flush = ($urandom % 20) == 0;
            set_rd($urandom_range(0, 8), ($urandom % 4 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 8));
            #1;
            chk_port(0, "rand_p0");
            chk_port(1, "rand_p1");
            tick();
        end
        idle();
        rdy_in = 1'b1;
        for (int i = 0; i < NREGS; i += 2) begin
            set_rd(i, i + 1); #1;
            chk_port(0, "final_p0");
            chk_port(1, "final_p1");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
